fetch_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-wait-state instruction/data memory between two requesters: the IF stage (instruction read) and the MEM stage (data read/write).
- Sequences each access through a wait-state FSM.
- Returns data with a one-cycle ready pulse.
- Generates the pipeline freeze for MEM accesses. IF stalls are reported through if_stall to the hazard/PC logic.

---
 rtl/fetch_mem_arbiter_pkg.sv | 7 +
 rtl/fetch_mem_arbiter_if.sv | 19 +
 rtl/fetch_mem_arbiter_wait_counter.sv | 16 +
 rtl/fetch_mem_arbiter.sv | 64 ++++++
 tb/tb_fetch_mem_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fetch_mem_arbiter_pkg.sv
// arm_mem_pkg: shared types and widths for the fetch/mem memory arbiter.
package arm_mem_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {GNT_IF, GNT_MEM} gnt_e;
endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// fetch_mem_arbiter_if: IF/MEM requester buses and the single-port memory bus.
interface fetch_mem_arbiter_if import arm_mem_pkg::*; #(parameter int ADDR_W = 16);
  logic if_req, if_flush, if_ready, if_stall;
  logic mem_rd_en, mem_wr_en, mem_ready, freeze;
  logic sram_en, sram_we;
  logic [WORD_W-1:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [WORD_W-1:0] sram_wdata, sram_rdata;
  logic [ADDR_W-1:0] sram_addr;
  modport slave (
    input if_req, if_addr, if_flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, freeze,
    output sram_en, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output if_req, if_addr, if_flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
    input if_rdata, if_ready, if_stall, mem_rdata, mem_ready, freeze,
    input sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/fetch_mem_arbiter_wait_counter.sv
// mem_wait_counter: loadable down-counter that stops at zero.
module mem_wait_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && !zero_o) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one wait-stated memory between IF and MEM, MEM first.
module fetch_mem_arbiter import arm_mem_pkg::*; #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W = 16
) (
  input logic clk,
  input logic rst_n,
  fetch_mem_arbiter_if.slave bus
);
  state_e state_q, state_d;
  gnt_e gnt_q, gnt_d;
  logic flush_q, flush_d;
  logic [WORD_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d, addr_sel;
  logic mem_req, grant, busy, resp, is_if, cnt_zero, kill_if, capture, if_ready, mem_ready, unused_bits;
  assign mem_req = bus.mem_rd_en | bus.mem_wr_en;
  assign busy = state_q == BUSY;
  assign resp = state_q == RESP;
  assign is_if = gnt_q == GNT_IF;
  assign grant = state_q == IDLE && (mem_req || (bus.if_req && !bus.if_flush));
  // A flush seen this cycle must suppress the IF result as well as one seen earlier.
  assign kill_if = flush_q | bus.if_flush;
  assign capture = busy & cnt_zero;
  assign addr_sel = is_if ? bus.if_addr : bus.mem_addr;
  assign unused_bits = ^{addr_sel[1:0], addr_sel[WORD_W-1:ADDR_W+2]};
  mem_wait_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load_i(grant), .dec_i(busy),
    .val_i(CNT_W'(WAIT_CYCLES)), .zero_o(cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= GNT_IF;
      flush_q <= 1'b0;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      flush_q <= flush_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (grant ? BUSY : IDLE) : busy ? (cnt_zero ? RESP : BUSY) : IDLE;
    gnt_d = grant ? (mem_req ? GNT_MEM : GNT_IF) : gnt_q;
    flush_d = resp ? 1'b0 : flush_q | (busy & is_if & bus.if_flush);
    if_rdata_d = capture && is_if && !kill_if ? bus.sram_rdata : if_rdata_q;
    mem_rdata_d = capture && !is_if && !bus.mem_wr_en ? bus.sram_rdata : mem_rdata_q;
  end
  always_comb begin
    if_ready = resp & is_if & ~kill_if;
    mem_ready = resp & ~is_if;
    bus.if_ready = if_ready;
    bus.mem_ready = mem_ready;
    bus.if_rdata = if_rdata_q;
    bus.mem_rdata = mem_rdata_q;
    bus.if_stall = rst_n & bus.if_req & ~if_ready;
    bus.freeze = rst_n & mem_req & ~mem_ready;
    bus.sram_en = busy;
    bus.sram_we = busy & ~is_if & bus.mem_wr_en;
    bus.sram_addr = busy ? addr_sel[ADDR_W+1:2] : '0;
    bus.sram_wdata = busy ? bus.mem_wdata : '0;
  end
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: random and directed accesses scored against a slot-based memory model.
module tb_fetch_mem_arbiter;
  localparam int W = 3;
  localparam int SLOT = W + 3;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic clk = 0, rst_n = 0;
  int cyc = 0, total = 0, bad = 0;
  exp_t if_q[$], mem_q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] sram_mem [1024];
  logic [31:0] last_ird = 0, last_mrd = 0;
  fetch_mem_arbiter_if #(.ADDR_W(16)) bus ();
  fetch_mem_arbiter_if #(.ADDR_W(16)) b0 ();
  fetch_mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.sram_rdata = sram_mem[bus.sram_addr[9:0]];
  assign b0.sram_rdata = {16'hC0DE, b0.sram_addr};
  always @(posedge clk) if (bus.sram_en && bus.sram_we) sram_mem[bus.sram_addr[9:0]] <= bus.sram_wdata;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @cyc %0d", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_ready) begin
      if (if_q.size() == 0) chk("if_ready_unexpected", 1, 0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", bus.if_rdata, e.d);
        chk("if_ready_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (bus.mem_ready) begin
      if (mem_q.size() == 0) chk("mem_ready_unexpected", 1, 0);
      else begin
        e = mem_q.pop_front();
        chk("mem_rdata", bus.mem_rdata, e.d);
        chk("mem_ready_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end
  // Each access owns a SLOT-cycle window: grant, WAIT+1 busy cycles, one response cycle.
  task automatic access(input bit di, input bit dm, input bit wr, input bit fl,
                        input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
    int t0, ns, ii, s, p;
    bit busy, gm, ir, mr;
    logic [31:0] a;
    @(posedge clk); #1;
    bus.if_req = di; bus.if_addr = ia;
    bus.mem_wr_en = dm & wr; bus.mem_rd_en = dm & (!wr | 1'($urandom_range(0, 1)));
    bus.mem_addr = ma; bus.mem_wdata = wd;
    t0 = cyc; ns = int'(di) + int'(dm); ii = dm ? 1 : 0;
    if (dm) begin
      if (wr) begin
        mem_q.push_back('{last_mrd, t0 + W + 2});
        ref_mem[ma[11:2]] = wd;
      end else begin
        last_mrd = ref_mem[ma[11:2]];
        mem_q.push_back('{last_mrd, t0 + W + 2});
      end
    end
    if (di && !fl) begin
      last_ird = ref_mem[ia[11:2]];
      if_q.push_back('{last_ird, t0 + ii * SLOT + W + 2});
    end
    for (int k = 0; k < ns * SLOT; k++) begin
      @(negedge clk);
      s = k / SLOT; p = k % SLOT;
      busy = p >= 1 && p <= W + 1;
      gm = dm && s == 0;
      chk("sram_en", 32'(bus.sram_en), 32'(busy));
      if (busy) begin
        a = gm ? ma : ia;
        chk("sram_addr", 32'(bus.sram_addr), 32'(a[17:2]));
        chk("sram_we", 32'(bus.sram_we), 32'(gm & wr));
        if (gm && wr) chk("sram_wdata", bus.sram_wdata, wd);
      end
      ir = di && !fl && k == ii * SLOT + W + 2;
      mr = dm && k == W + 2;
      chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req & !ir));
      chk("freeze", 32'(bus.freeze), 32'((bus.mem_rd_en | bus.mem_wr_en) & !mr));
      @(posedge clk); #1;
      if (mr) begin bus.mem_rd_en = 0; bus.mem_wr_en = 0; end
      if (ir) bus.if_req = 0;
      if (fl && k + 1 == 2) begin bus.if_flush = 1; bus.if_req = 0; end
      if (fl && k + 1 == 3) bus.if_flush = 0;
    end
    if (fl) chk("if_rdata_kept", bus.if_rdata, last_ird);
  endtask
  task automatic check_zero(input string n);
    chk({n, "_sram_en"}, 32'(bus.sram_en), 0);
    chk({n, "_sram_we"}, 32'(bus.sram_we), 0);
    chk({n, "_sram_addr"}, 32'(bus.sram_addr), 0);
    chk({n, "_sram_wdata"}, bus.sram_wdata, 0);
    chk({n, "_if_ready"}, 32'(bus.if_ready), 0);
    chk({n, "_mem_ready"}, 32'(bus.mem_ready), 0);
    chk({n, "_if_rdata"}, bus.if_rdata, 0);
    chk({n, "_mem_rdata"}, bus.mem_rdata, 0);
    chk({n, "_if_stall"}, 32'(bus.if_stall), 0);
    chk({n, "_freeze"}, 32'(bus.freeze), 0);
  endtask
  initial begin
    int t0, kind;
    logic [31:0] ia, ma;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      sram_mem[i] = ref_mem[i];
    end
    ref_mem[2] = 32'hE3A00001; sram_mem[2] = 32'hE3A00001;
    {bus.if_req, bus.if_flush, bus.mem_rd_en, bus.mem_wr_en} = '0;
    bus.if_addr = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    {b0.if_req, b0.if_flush, b0.mem_rd_en, b0.mem_wr_en} = '0;
    b0.if_addr = 0; b0.mem_addr = 0; b0.mem_wdata = 0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    access(1, 0, 0, 0, 32'h8, 0, 0);
    access(1, 1, 0, 0, 32'h10, 32'h400, 0);
    access(0, 1, 1, 0, 0, 32'h40, 32'hDEADBEEF);
    access(1, 0, 0, 1, 32'hC, 0, 0);
    access(1, 0, 0, 0, 32'h40, 0, 0);
    @(posedge clk); #1;
    bus.if_req = 1; bus.if_addr = 32'h20;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 check_zero("async_rst");
    bus.if_req = 0; last_ird = 0; last_mrd = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (4) @(posedge clk);
    access(1, 0, 0, 0, 32'h20, 0, 0);
    access(0, 1, 0, 0, 0, 32'h40, 0);
    @(posedge clk); #1;
    b0.mem_rd_en = 1; b0.mem_addr = 32'h24;
    @(negedge clk) chk("w0_sram_en_c0", 32'(b0.sram_en), 0);
    @(negedge clk);
    chk("w0_sram_en_c1", 32'(b0.sram_en), 1);
    chk("w0_sram_addr", 32'(b0.sram_addr), 9);
    @(negedge clk);
    chk("w0_mem_ready_c2", 32'(b0.mem_ready), 1);
    chk("w0_mem_rdata", b0.mem_rdata, 32'hC0DE0009);
    chk("w0_sram_en_c2", 32'(b0.sram_en), 0);
    @(posedge clk); #1 b0.mem_rd_en = 0;
    @(negedge clk) chk("w0_mem_ready_c3", 32'(b0.mem_ready), 0);
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      ia = 32'($urandom_range(0, 1023)) << 2;
      ma = ($urandom_range(0, 1) == 1) ? ia : 32'($urandom_range(0, 1023)) << 2;
      case (kind)
        0: access(1, 0, 0, 0, ia, ma, $urandom);
        1: access(0, 1, 0, 0, ia, ma, $urandom);
        2: access(0, 1, 1, 0, ia, ma, $urandom);
        3: access(1, 1, 1'($urandom_range(0, 1)), 0, ia, ma, $urandom);
        default: access(1, 0, 0, 1, ia, ma, $urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("if_q_drained", 32'(if_q.size()), 0);
    chk("mem_q_drained", 32'(mem_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
